blob_centroid: RTL and testbench

//  Multi-channel blob centroid engine for the camera tracking path. Per colour class,

---
 rtl/blob_centroid_pkg.sv | 10 +
 rtl/centroid_div.sv | 43 ++++
 rtl/blob_centroid.sv | 126 ++++++++++++
 tb/tb_blob_centroid.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/blob_centroid_pkg.sv
// blob_centroid_pkg: sequencer state encoding and derived widths shared by the centroid engine.
package blob_centroid_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DIV, EMIT} state_t;
  function automatic int sum_w(input int coord_w, input int cnt_w);
    return coord_w + cnt_w;
  endfunction
  function automatic int ch_w(input int num_ch);
    return num_ch > 1 ? $clog2(num_ch) : 1;
  endfunction
endpackage

// File: rtl/centroid_div.sv
// centroid_div: serial restoring divider, one quotient bit per cycle, done flags the final step.
module centroid_div #(
  parameter int COORD_W = 16,
  parameter int CNT_W   = 20,
  parameter int SUM_W   = COORD_W + CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [SUM_W-1:0]   numer,
  input  logic [CNT_W-1:0]   denom,
  output logic [COORD_W-1:0] quotient,
  output logic               done
);
  localparam int IW = $clog2(COORD_W + 1);
  logic [CNT_W-1:0] rem_q;
  logic [COORD_W-1:0] sh_q;
  logic [IW-1:0] cnt_q;
  logic [CNT_W:0] trial;
  logic ge;
  // sh_q holds the unconsumed numerator bits and collects quotient bits from the bottom
  always_comb begin
    trial = {rem_q, sh_q[COORD_W-1]};
    ge = trial >= {1'b0, denom};
    quotient = {sh_q[COORD_W-2:0], ge};
    done = cnt_q == IW'(1);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q <= '0;
      sh_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      rem_q <= numer[SUM_W-1 -: CNT_W];
      sh_q <= numer[COORD_W-1:0];
      cnt_q <= IW'(COORD_W);
    end else if (cnt_q != '0) begin
      rem_q <= ge ? CNT_W'(trial - {1'b0, denom}) : trial[CNT_W-1:0];
      sh_q <= quotient;
      cnt_q <= cnt_q - 1'b1;
    end
  end
endmodule

// File: rtl/blob_centroid.sv
// blob_centroid: per-class frame accumulators, eof snapshot and channel-serial centroid division.
module blob_centroid import blob_centroid_pkg::*; #(
  parameter int NUM_CH     = 4,
  parameter int COORD_W    = 16,
  parameter int CNT_W      = 20,
  parameter int MIN_PIXELS = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pix_valid,
  input  logic                      sof,
  input  logic                      eof,
  input  logic [COORD_W-1:0]        x_row,
  input  logic [COORD_W-1:0]        y_col,
  input  logic [NUM_CH-1:0]         pix_class,
  output logic [COORD_W-1:0]        center_x,
  output logic [COORD_W-1:0]        center_y,
  output logic [CNT_W-1:0]          cent_count,
  output logic                      found,
  output logic [ch_w(NUM_CH)-1:0]   cent_ch,
  output logic                      cent_valid,
  output logic                      frame_done,
  output logic                      busy,
  output logic                      overrun
);
  localparam int SUM_W = sum_w(COORD_W, CNT_W);
  localparam int CH_W = ch_w(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [SUM_W-1:0] sx_q [NUM_CH];
  logic [SUM_W-1:0] sy_q [NUM_CH];
  logic [CNT_W-1:0] n_q [NUM_CH];
  logic [SUM_W-1:0] sx_d [NUM_CH];
  logic [SUM_W-1:0] sy_d [NUM_CH];
  logic [CNT_W-1:0] n_d [NUM_CH];
  logic [SUM_W-1:0] snx_q [NUM_CH];
  logic [SUM_W-1:0] sny_q [NUM_CH];
  logic [CNT_W-1:0] snn_q [NUM_CH];
  state_t state_q;
  logic [CH_W-1:0] ch_q;
  logic [CNT_W-1:0] sel_n;
  logic [COORD_W-1:0] qx, qy;
  logic done_x, done_y, frame_end, skip, last, start, emit;
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      sx_d[c] = sx_q[c];
      sy_d[c] = sy_q[c];
      n_d[c] = n_q[c];
      if (pix_valid && sof) begin
        sx_d[c] = pix_class[c] ? SUM_W'(x_row) : '0;
        sy_d[c] = pix_class[c] ? SUM_W'(y_col) : '0;
        n_d[c] = pix_class[c] ? CNT_W'(1) : '0;
      end else if (pix_valid && pix_class[c] && n_q[c] != CNT_MAX) begin
        sx_d[c] = sx_q[c] + SUM_W'(x_row);
        sy_d[c] = sy_q[c] + SUM_W'(y_col);
        n_d[c] = n_q[c] + 1'b1;
      end
    end
  end
  // a zero count always takes the skip path so the divider never sees denom 0
  assign frame_end = pix_valid & eof;
  assign busy = state_q != IDLE;
  assign overrun = frame_end & busy;
  assign sel_n = snn_q[ch_q];
  assign skip = int'(sel_n) < MIN_PIXELS || sel_n == '0;
  assign last = ch_q == CH_W'(NUM_CH - 1);
  assign start = state_q == LOAD && !skip;
  assign emit = (state_q == LOAD && skip) || (state_q == DIV && done_x && done_y);
  centroid_div #(.COORD_W(COORD_W), .CNT_W(CNT_W), .SUM_W(SUM_W)) u_div_x (
    .clk(clk), .reset(reset), .start(start), .numer(snx_q[ch_q]), .denom(sel_n),
    .quotient(qx), .done(done_x)
  );
  centroid_div #(.COORD_W(COORD_W), .CNT_W(CNT_W), .SUM_W(SUM_W)) u_div_y (
    .clk(clk), .reset(reset), .start(start), .numer(sny_q[ch_q]), .denom(sel_n),
    .quotient(qy), .done(done_y)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        sx_q[c] <= '0;
        sy_q[c] <= '0;
        n_q[c] <= '0;
        snx_q[c] <= '0;
        sny_q[c] <= '0;
        snn_q[c] <= '0;
      end
      state_q <= IDLE;
      ch_q <= '0;
      center_x <= '0;
      center_y <= '0;
      cent_count <= '0;
      found <= 1'b0;
      cent_ch <= '0;
      cent_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      sx_q <= sx_d;
      sy_q <= sy_d;
      n_q <= n_d;
      cent_valid <= emit;
      frame_done <= emit && last;
      // snapshot takes the post-update sums so the eof pixel itself is included
      if (frame_end && !busy) begin
        snx_q <= sx_d;
        sny_q <= sy_d;
        snn_q <= n_d;
      end
      if (emit) begin
        center_x <= skip ? '0 : qx;
        center_y <= skip ? '0 : qy;
        cent_count <= sel_n;
        found <= !skip;
        cent_ch <= ch_q;
      end
      case (state_q)
        IDLE: if (frame_end) state_q <= LOAD;
        LOAD: state_q <= skip ? EMIT : DIV;
        DIV: if (done_x && done_y) state_q <= EMIT;
        EMIT: begin
          state_q <= last ? IDLE : LOAD;
          ch_q <= last ? '0 : ch_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_blob_centroid.sv
// tb_blob_centroid: scoreboard bench driving a default instance and a CNT_W=4/MIN_PIXELS=1 instance in parallel.
module tb_blob_centroid;
  typedef struct {
    longint cx, cy, cnt;
    bit f;
    int ch;
    bit last;
    int t;
  } exp_t;
  logic clk = 0, reset = 1, pix_valid = 0, sof = 0, eof = 0;
  logic [15:0] x_row = 0, y_col = 0;
  logic [3:0] pix_class = 0;
  logic [15:0] a_cx, a_cy, b_cx, b_cy;
  logic [19:0] a_cnt;
  logic [3:0] b_cnt;
  logic [1:0] a_ch, b_ch;
  logic a_f, b_f, a_cv, b_cv, a_fd, b_fd, a_busy, b_busy, a_ov, b_ov;
  int cyc = 0, n_chk = 0, n_err = 0;
  longint mx [2][4], my [2][4], mn [2][4];
  longint cmax [2] = '{1048575, 15};
  int minp [2] = '{16, 1};
  int busy_until [2] = '{-1, -1};
  exp_t sb_a [$], sb_b [$];
  int ov_a [$], ov_b [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  blob_centroid dut_a (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .sof(sof), .eof(eof),
    .x_row(x_row), .y_col(y_col), .pix_class(pix_class),
    .center_x(a_cx), .center_y(a_cy), .cent_count(a_cnt), .found(a_f), .cent_ch(a_ch),
    .cent_valid(a_cv), .frame_done(a_fd), .busy(a_busy), .overrun(a_ov)
  );
  blob_centroid #(.NUM_CH(4), .COORD_W(16), .CNT_W(4), .MIN_PIXELS(1)) dut_b (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .sof(sof), .eof(eof),
    .x_row(x_row), .y_col(y_col), .pix_class(pix_class),
    .center_x(b_cx), .center_y(b_cy), .cent_count(b_cnt), .found(b_f), .cent_ch(b_ch),
    .cent_valid(b_cv), .frame_done(b_fd), .busy(b_busy), .overrun(b_ov)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_eof(input int t0);
    for (int d = 0; d < 2; d++) begin
      if (t0 <= busy_until[d]) begin
        if (d == 0) ov_a.push_back(t0);
        else ov_b.push_back(t0);
      end else begin
        int t = t0;
        for (int c = 0; c < 4; c++) begin
          exp_t e;
          e.f = mn[d][c] >= minp[d] && mn[d][c] > 0;
          t += e.f ? 18 : 2;
          e.cx = e.f ? mx[d][c] / mn[d][c] : 0;
          e.cy = e.f ? my[d][c] / mn[d][c] : 0;
          e.cnt = mn[d][c];
          e.ch = c;
          e.last = c == 3;
          e.t = t;
          if (d == 0) sb_a.push_back(e);
          else sb_b.push_back(e);
        end
        busy_until[d] = t;
      end
    end
  endtask

  task automatic px(input logic [15:0] x, input logic [15:0] y, input logic [3:0] cls,
                    input logic s, input logic e);
    @(posedge clk);
    #1;
    pix_valid = 1; x_row = x; y_col = y; pix_class = cls; sof = s; eof = e;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++) begin
        if (s) begin
          mx[d][c] = cls[c] ? longint'(x) : 0;
          my[d][c] = cls[c] ? longint'(y) : 0;
          mn[d][c] = cls[c] ? 1 : 0;
        end else if (cls[c] && mn[d][c] < cmax[d]) begin
          mx[d][c] += longint'(x);
          my[d][c] += longint'(y);
          mn[d][c] += 1;
        end
      end
    if (e) model_eof(cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      pix_valid = 0; sof = 0; eof = 0; pix_class = 0;
    end
  endtask

  task automatic drain();
    int lim = (busy_until[0] > busy_until[1] ? busy_until[0] : busy_until[1]) + 3;
    while (cyc < lim) idle(1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a"}, longint'({a_cx, a_cy, a_cnt, a_f, a_ch, a_cv, a_fd, a_busy, a_ov}), 0);
    chk({tag, "_b"}, longint'({b_cx, b_cy, b_cnt, b_f, b_ch, b_cv, b_fd, b_busy, b_ov}), 0);
  endtask

  task automatic mon(input int d, input logic cv, input logic fd, input logic ov,
                     input longint cx, input longint cy, input longint cnt,
                     input logic f, input longint ch);
    exp_t e;
    if (ov) begin
      if ((d == 0 ? ov_a.size() : ov_b.size()) == 0) chk($sformatf("ovr_unexp%0d", d), ov, 0);
      else if (d == 0) chk("ovr_cyc0", cyc, ov_a.pop_front());
      else chk("ovr_cyc1", cyc, ov_b.pop_front());
    end
    if (fd && !cv) chk($sformatf("fd_alone%0d", d), fd, cv);
    if (cv) begin
      if ((d == 0 ? sb_a.size() : sb_b.size()) == 0) chk($sformatf("cv_unexp%0d", d), cv, 0);
      else begin
        e = d == 0 ? sb_a.pop_front() : sb_b.pop_front();
        chk($sformatf("cx%0d_ch%0d", d, e.ch), cx, e.cx);
        chk($sformatf("cy%0d_ch%0d", d, e.ch), cy, e.cy);
        chk($sformatf("cnt%0d_ch%0d", d, e.ch), cnt, e.cnt);
        chk($sformatf("found%0d_ch%0d", d, e.ch), f, e.f);
        chk($sformatf("chidx%0d", d), ch, e.ch);
        chk($sformatf("fdone%0d_ch%0d", d, e.ch), fd, e.last);
        chk($sformatf("cvcyc%0d_ch%0d", d, e.ch), cyc, e.t);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, a_cv, a_fd, a_ov, a_cx, a_cy, a_cnt, a_f, a_ch);
    mon(1, b_cv, b_fd, b_ov, b_cx, b_cy, b_cnt, b_f, b_ch);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_out");
    reset = 0;
    idle(2);
    // ch0 centroid (13,23); ch2 gets 12 pixels: skipped on dut_a, divided on dut_b
    px(10, 20, 4'b0001, 1, 0);
    px(12, 22, 4'b0001, 0, 0);
    px(14, 24, 4'b0001, 0, 0);
    px(16, 26, 4'b0001, 0, 0);
    for (int i = 0; i < 12; i++) px(13, 23, 4'b0101, 0, i == 11);
    idle(1);
    chk("busy_after_eof", a_busy, 1);
    drain();
    chk("busy_idle", a_busy, 0);
    // floor: x sum 17 over 16 pixels
    px(2, 5, 4'b0001, 1, 0);
    for (int i = 0; i < 15; i++) px(1, 5, 4'b0001, 0, i == 14);
    drain();
    px(100, 200, 4'b0001, 1, 1);
    drain();
    // second eof while busy is dropped
    for (int i = 0; i < 16; i++) px(16'(100 + i), 50, 4'b0010, i == 0, i == 15);
    idle(4);
    px(0, 0, 4'b0000, 0, 1);
    drain();
    // reset mid-division
    for (int i = 0; i < 16; i++) px(16'(i * 3), 7, 4'b0001, i == 0, i == 15);
    idle(7);
    @(posedge clk);
    #3;
    reset = 1;
    #1;
    chk_zero("async_reset");
    sb_a.delete(); sb_b.delete(); ov_a.delete(); ov_b.delete();
    busy_until = '{-1, -1};
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++) begin
        mx[d][c] = 0; my[d][c] = 0; mn[d][c] = 0;
      end
    @(posedge clk);
    #1;
    reset = 0;
    idle(3);
    // saturation on the CNT_W=4 instance
    for (int i = 0; i < 20; i++) px(16'(10 + i), 16'(i), 4'b0001, i == 0, i == 19);
    drain();
    for (int i = 0; i < 30; i++)
      px(16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)), i == 0, i == 29);
    drain();
    idle(5);
    chk("sb_left_a", sb_a.size(), 0);
    chk("sb_left_b", sb_b.size(), 0);
    chk("ovr_left", ov_a.size() + ov_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
